// File: rtl/scan_if.sv
// Control and channel-select bundle between a scan controller and scan_sequencer.
interface scan_if;
    logic        start;
    logic        stop;
    logic        continuous;
    logic [15:0] mask;
    logic [3:0]  period;
    logic        sel_en_n;
    logic [3:0]  sel;
    logic        busy;
    logic        done;
    logic [7:0]  sweeps;

    modport master (
        output start, stop, continuous, mask, period,
        input  sel_en_n, sel, busy, done, sweeps
    );

    modport slave (
        input  start, stop, continuous, mask, period,
        output sel_en_n, sel, busy, done, sweeps
    );
endinterface

// File: rtl/scan_sequencer.sv
// Sweeps enabled channels of a 16-way active-low decoder with a fixed dwell
// and a one-cycle break-before-make gap between channel changes.
module scan_sequencer (
    input  logic   clk,
    input  logic   reset_n,
    scan_if.slave  bus
);
    localparam int unsigned NCH   = 16;
    localparam int unsigned SEL_W = 4;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned SWP_W = 8;

    typedef enum logic [1:0] {IDLE, DWELL, GAP, FIN} state_e;

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               sel_en_n_q, sel_en_n_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [SWP_W-1:0]   sweeps_q, sweeps_d;
    logic [NCH-1:0]     mask_q, mask_d;
    logic [CNT_W-1:0]   period_q, period_d;
    logic               cont_q, cont_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    // Lowest set bit of m at index >= from; returns {found, index}.
    function automatic logic [SEL_W:0] lowest_from(input logic [NCH-1:0] m,
                                                   input logic [SEL_W:0] from);
        logic             found;
        logic [SEL_W-1:0] idx;
        found = 1'b0;
        idx   = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (m[i] && ((SEL_W+1)'(i) >= from)) begin
                found = 1'b1;
                idx   = SEL_W'(i);
            end
        end
        return {found, idx};
    endfunction

    logic [SEL_W:0] above_c;
    logic [SEL_W:0] first_c;
    logic [SEL_W:0] start_first_c;

    always_comb begin
        above_c       = lowest_from(mask_q, {1'b0, sel_q} + (SEL_W+1)'(1));
        first_c       = lowest_from(mask_q, '0);
        start_first_c = lowest_from(bus.mask, '0);

        state_d    = state_q;
        sel_d      = sel_q;
        sel_en_n_d = sel_en_n_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        sweeps_d   = sweeps_q;
        mask_d     = mask_q;
        period_d   = period_q;
        cont_d     = cont_q;
        cnt_d      = cnt_q;

        case (state_q)
            IDLE: begin
                sel_en_n_d = 1'b1;
                busy_d     = 1'b0;
                if (bus.start && !bus.stop) begin
                    mask_d   = bus.mask;
                    period_d = bus.period;
                    cont_d   = bus.continuous;
                    sweeps_d = '0;
                    if (bus.mask != '0) begin
                        state_d    = DWELL;
                        sel_d      = start_first_c[SEL_W-1:0];
                        sel_en_n_d = 1'b0;
                        busy_d     = 1'b1;
                        cnt_d      = bus.period;
                    end else begin
                        state_d = FIN;
                        done_d  = 1'b1;
                    end
                end
            end
            DWELL: begin
                if (bus.stop) begin
                    state_d    = IDLE;
                    sel_en_n_d = 1'b1;
                    busy_d     = 1'b0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (above_c[SEL_W]) begin
                    state_d    = GAP;
                    sel_en_n_d = 1'b1;
                end else begin
                    // Last dwell of the sweep: count it, then wrap or finish.
                    sweeps_d   = (sweeps_q == '1) ? sweeps_q : sweeps_q + SWP_W'(1);
                    sel_en_n_d = 1'b1;
                    if (cont_q) begin
                        state_d = GAP;
                    end else begin
                        state_d = FIN;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            GAP: begin
                if (bus.stop) begin
                    state_d    = IDLE;
                    sel_en_n_d = 1'b1;
                    busy_d     = 1'b0;
                end else begin
                    // No higher channel means this gap is the wrap-around.
                    state_d    = DWELL;
                    sel_d      = above_c[SEL_W] ? above_c[SEL_W-1:0] : first_c[SEL_W-1:0];
                    sel_en_n_d = 1'b0;
                    cnt_d      = period_q;
                end
            end
            FIN: begin
                state_d    = IDLE;
                sel_en_n_d = 1'b1;
                busy_d     = 1'b0;
            end
            default: begin
                state_d    = IDLE;
                sel_en_n_d = 1'b1;
                busy_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            sel_q      <= '0;
            sel_en_n_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sweeps_q   <= '0;
            mask_q     <= '0;
            period_q   <= '0;
            cont_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            sel_en_n_q <= sel_en_n_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            sweeps_q   <= sweeps_d;
            mask_q     <= mask_d;
            period_q   <= period_d;
            cont_q     <= cont_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.sel      = sel_q;
    assign bus.sel_en_n = sel_en_n_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.sweeps   = sweeps_q;
endmodule

// File: doc/scan_sequencer.md
SCAN_SEQUENCER -- requirements
Module: scan_sequencer

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 The block SHALL have port reset_n, input, 1 bit: synchronous, active-low reset, sampled on rising clk.
REQ-003 The block SHALL have port start, input, 1 bit: request a scan; sampled only in IDLE.
REQ-004 The block SHALL have port stop, input, 1 bit: abort the scan; honoured in any non-IDLE state.
REQ-005 The block SHALL have port continuous, input, 1 bit: 1 = repeat sweeps until stop, 0 = single sweep; latched at accepted start.
REQ-006 The block SHALL have port mask, input, 16 bits: bit i = 1 enables channel i; latched at accepted start.
REQ-007 The block SHALL have port period, input, 4 bits: dwell length minus 1, in cycles; latched at accepted start.
REQ-008 The block SHALL have port sel_en_n, output, 1 bit: active-low enable to the downstream 4-to-16 active-low decoder.
REQ-009 The block SHALL have port sel, output, 4 bits: channel index to the downstream decoder.
REQ-010 The block SHALL have port busy, output, 1 bit: high in DWELL and GAP.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle pulse at the end of a single sweep.
REQ-012 The block SHALL have port sweeps, output, 8 bits: count of completed sweeps since the last accepted start; saturates at 255.

Function
REQ-013 The FSM SHALL have the states IDLE, DWELL, GAP and FIN; all outputs SHALL be registered.
REQ-014 IDLE: sel_en_n = 1 and busy = 0; sel holds its last value.
REQ-015 Start acceptance: an accepted start requires start=1, stop=0, state=IDLE; start=1 in any other state SHALL be ignored.
REQ-016 Start with latched mask ≠ 0: the next cycle SHALL enter DWELL with sel = lowest enabled channel, sel_en_n = 0, busy = 1, sweeps = 0.
REQ-017 Start with mask = 0: the next cycle SHALL enter FIN (done = 1, sel_en_n = 1, sweeps = 0) with no dwell, regardless of continuous.
REQ-018 DWELL SHALL hold sel_en_n = 0 and sel stable for exactly period+1 cycles; the internal 4-bit down-counter is loaded with period on DWELL entry.
REQ-019 Break-before-make: every channel change SHALL pass through GAP, exactly 1 cycle with sel_en_n = 1, busy = 1, and sel still equal to the old channel; sel updates on GAP exit.
REQ-020 Next channel SHALL be the lowest enabled index strictly above the current index; disabled channels SHALL never be driven.
REQ-021 End of sweep: the sweep ends when no enabled index lies above the current one; sweeps increments (saturating) on the last DWELL cycle of the sweep.
REQ-022 Single mode: after the last DWELL the block SHALL enter FIN for 1 cycle (done = 1, busy = 0, sel_en_n = 1), then IDLE.
REQ-023 Continuous mode: after the last DWELL the block SHALL enter GAP, then DWELL on the lowest enabled channel (wrap-around); done stays 0.
REQ-024 Single enabled channel, continuous: the block SHALL alternate DWELL (period+1 cycles) and GAP (1 cycle) on that channel.
REQ-025 Stop: stop=1 in DWELL/GAP/FIN SHALL force IDLE on the next cycle with sel_en_n = 1, busy = 0, done = 0; sweeps holds.
REQ-026 Simultaneous stop with a dwell or sweep end: stop SHALL take precedence, so no done pulse and no increment in that cycle.
REQ-027 Input changes: changes to mask, period and continuous while busy SHALL have no effect until the next accepted start.

Reset
REQ-028 Reset value: reset_n = 0 at a rising edge SHALL give state = IDLE, sel_en_n = 1, sel = 0, busy = 0, done = 0, sweeps = 0, and clear the latched mask, period, continuous and counter.
REQ-029 Reset precedence: reset SHALL override start and stop and take effect mid-DWELL with sel_en_n = 1 on the next cycle; no done pulse.

Verification
REQ-030 Single sweep: mask = 16'h0005, period = 2, continuous = 0, start pulse -> ch0 low 3 cycles, 1 GAP, ch2 low 3 cycles, done pulse 1 cycle, sweeps = 1, IDLE.
REQ-031 Continuous wrap: mask = 16'h8001, period = 0, continuous = 1 -> sel sequence 0,0(gap),15,15(gap),0,...; after 3 sweeps sweeps = 3; stop -> sel_en_n = 1 next cycle, busy = 0, no done.
REQ-032 Empty mask: mask = 16'h0000 -> done high exactly 1 cycle after start, sel_en_n never 0.
REQ-033 Mid-scan events: start held high and mask changed to 16'hFFFF during a scan with mask = 16'h0010 -> only ch4 driven; reset_n = 0 mid-DWELL -> all REQ-028 values next cycle.
REQ-034 Saturation: single channel, period = 0, continuous run of 300 sweeps -> sweeps = 255 and holds.
REQ-035 Invariant checks: sel_en_n = 0 always implies mask_latched[sel] = 1; sel never changes while sel_en_n = 0.
